// File: rtl/jtframe_rst_pkg.sv
// Shared types and constants for the jtframe reset sequencer.
// The sequencer is made of the top FSM plus one lock watcher per PLL.
package jtframe_rst_pkg;

    typedef enum logic [1:0] {
        S_LOCK  = 2'd0,
        S_HOLD  = 2'd1,
        S_STAGE = 2'd2,
        S_RUN   = 2'd3
    } state_e;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_REQ  = 2'd2;
    localparam logic [1:0] CAUSE_DL   = 2'd3;

    // One spare bit so that the count value itself always fits.
    function automatic int cnt_w(input int v);
        return $clog2(v) + 1;
    endfunction

endpackage

// File: rtl/jtframe_pll_watch.sv
// Lock watcher for one PLL: synchronises the lock flag and pulses pll_rst
// on lock loss, or when the PLL has stayed unlocked for too long.
module jtframe_pll_watch
    import jtframe_rst_pkg::*;
#(
    parameter int HOLD_CNT = 256,
    parameter int LOCK_TO  = 65536
) (
    input  logic clk_sys,
    input  logic RESET,
    input  logic pll_locked,
    output logic pll_rst,
    output logic lock_sync
);

    localparam int HW = cnt_w(HOLD_CNT);
    localparam int TW = cnt_w(LOCK_TO);

    logic [1:0]    sync_q;
    logic          lock_prev_q;
    logic          pll_rst_q;
    logic [HW-1:0] hold_q, hold_d;
    logic [TW-1:0] to_q, to_d;
    logic          trig;

    always_comb begin
        trig   = 1'b0;
        hold_d = hold_q;
        to_d   = to_q;
        // The timeout only runs while the PLL is unlocked and not being reset.
        if (sync_q[1] || pll_rst_q) begin
            to_d = '0;
        end else begin
            to_d = to_q + TW'(1);
            if (to_d == TW'(LOCK_TO))
                trig = 1'b1;
        end
        if (!sync_q[1] && lock_prev_q)
            trig = 1'b1;
        if (trig) begin
            hold_d = HW'(HOLD_CNT);
            to_d   = '0;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            sync_q      <= '0;
            lock_prev_q <= 1'b0;
            pll_rst_q   <= 1'b0;
            hold_q      <= '0;
            to_q        <= '0;
        end else begin
            sync_q      <= {sync_q[0], pll_locked};
            lock_prev_q <= sync_q[1];
            pll_rst_q   <= (hold_d != '0);
            hold_q      <= hold_d;
            to_q        <= to_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign lock_sync = sync_q[1];

endmodule

// File: rtl/jtframe_rst_seq.sv
// Reset sequencer: waits for stable PLL lock, releases rst, then game_rst,
// and holds the game in reset on user requests or ROM download.
module jtframe_rst_seq
    import jtframe_rst_pkg::*;
#(
    parameter int NPLL     = 2,
    parameter int NREQ     = 3,
    parameter int HOLD_CNT = 256,
    parameter int STAGGER  = 16,
    parameter int LOCK_TO  = 65536
) (
    input  logic            clk_sys,
    input  logic            RESET,
    input  logic [NPLL-1:0] pll_locked,
    output logic [NPLL-1:0] pll_rst,
    input  logic [NREQ-1:0] rst_req,
    input  logic            downloading,
    output logic            rst,
    output logic            game_rst,
    output logic            game_rst_n,
    output logic [1:0]      cause,
    output logic [7:0]      lost_cnt
);

    localparam int CW = cnt_w(HOLD_CNT > STAGGER ? HOLD_CNT : STAGGER);

    logic [NPLL-1:0] lock_sync;
    logic            all_lock, all_lock_prev_q;
    logic [NREQ-1:0] req_s1_q, req_s2_q;
    logic [1:0]      dl_s_q;
    logic            req, busy;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      cause_q, cause_d;
    logic [7:0]      lost_q, lost_d;
    logic            rst_q, rst_d;
    logic            game_rst_q, game_rst_d;
    logic            game_rst_n_q;

    generate
        for (genvar gi = 0; gi < NPLL; gi++) begin : g_watch
            jtframe_pll_watch #(
                .HOLD_CNT (HOLD_CNT),
                .LOCK_TO  (LOCK_TO)
            ) u_watch (
                .clk_sys    (clk_sys),
                .RESET      (RESET),
                .pll_locked (pll_locked[gi]),
                .pll_rst    (pll_rst[gi]),
                .lock_sync  (lock_sync[gi])
            );
        end
    endgenerate

    assign all_lock = &lock_sync;
    assign req      = |req_s2_q;
    assign busy     = req | dl_s_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        lost_d  = lost_q;
        case (state_q)
            S_LOCK: begin
                if (all_lock) begin
                    state_d = S_HOLD;
                    cnt_d   = CW'(HOLD_CNT - 1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_STAGE;
                    cnt_d   = CW'(STAGGER - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STAGE: begin
                if (busy)
                    cnt_d = CW'(STAGGER - 1);
                else if (cnt_q == '0)
                    state_d = S_RUN;
                else
                    cnt_d = cnt_q - CW'(1);
            end
            S_RUN: begin
                if (busy) begin
                    state_d = S_STAGE;
                    cnt_d   = CW'(STAGGER - 1);
                    cause_d = req ? CAUSE_REQ : CAUSE_DL;
                end
            end
            default: state_d = S_LOCK;
        endcase
        // Losing lock overrides whatever the state logic decided above.
        if (!all_lock) begin
            state_d = S_LOCK;
            cnt_d   = '0;
            if (state_q != S_LOCK)
                cause_d = CAUSE_LOCK;
        end
        if (!all_lock && all_lock_prev_q && lost_q != 8'hFF)
            lost_d = lost_q + 8'd1;
        rst_d      = (state_d == S_LOCK) || (state_d == S_HOLD);
        game_rst_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            req_s1_q        <= '0;
            req_s2_q        <= '0;
            dl_s_q          <= '0;
            all_lock_prev_q <= 1'b0;
            state_q         <= S_LOCK;
            cnt_q           <= '0;
            cause_q         <= CAUSE_POR;
            lost_q          <= '0;
            rst_q           <= 1'b1;
            game_rst_q      <= 1'b1;
            game_rst_n_q    <= 1'b0;
        end else begin
            req_s1_q        <= rst_req;
            req_s2_q        <= req_s1_q;
            dl_s_q          <= {dl_s_q[0], downloading};
            all_lock_prev_q <= all_lock;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            cause_q         <= cause_d;
            lost_q          <= lost_d;
            rst_q           <= rst_d;
            game_rst_q      <= game_rst_d;
            game_rst_n_q    <= ~game_rst_d;
        end
    end

    assign rst        = rst_q;
    assign game_rst   = game_rst_q;
    assign game_rst_n = game_rst_n_q;
    assign cause      = cause_q;
    assign lost_cnt   = lost_q;

endmodule
